// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM states,
// default bus widths and queue sizing helpers.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int ENTRY_W_DEF = ADDR_W_DEF + DATA_W_DEF;

  // Memory handshake states: IDLE may accept a PC, WAIT has a live fetch,
  // DRAIN has a fetch whose result will be thrown away after a flush.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Occupancy counter width: must be able to hold DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the PC-side, memory-side and decode-side signals of the fetch
// queue. The slave modport is the fetch block; master is its environment.
interface instr_fetch_queue_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEF,
  parameter int DATA_W = fetch_pkg::DATA_W_DEF,
  parameter int DEPTH  = 4
);
  import fetch_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  // PC stage
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  // Instruction memory
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  // Redirect
  logic              flush;
  // Decode stage
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_instr;
  logic              if_ready;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  pc_in, pc_valid, imem_ack, imem_rdata, flush, if_ready,
    output pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, count
  );

  modport master (
    output pc_in, pc_valid, imem_ack, imem_rdata, flush, if_ready,
    input  pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, count
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a synchronous clear.
// Reads are combinational from the head slot so decode sees the entry in the
// same cycle if_valid rises; an empty queue presents all-zero data.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = ENTRY_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        valid_o,
  output logic                        full_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign count_o = count_q;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

  // Clear wins over both push and pop; a push into a full queue is refused.
  assign push_en = push_i && !clear_i && !full_o;
  assign pop_en  = pop_i && valid_o && !clear_i;

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: accepts PCs, runs a single-outstanding instruction memory
// request and queues the returned {pc, instr} pairs for decode. A flush
// empties the queue; a fetch already in flight is allowed to complete and
// its data is discarded, since the memory handshake cannot be aborted.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input logic                 CLK,
  input logic                 MasterReset,
  instr_fetch_queue_if.slave  bus
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = cnt_width(DEPTH);

  fetch_state_e      state_q;
  logic              imem_req_q;
  logic [ADDR_W-1:0] imem_addr_q;

  logic               pc_ready;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               head_valid;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fifo_count;

  // A PC is only taken in IDLE with a free slot; that slot stays reserved
  // for the fetch because only pops can change the count until it returns.
  assign pc_ready = (state_q == IDLE) && !fifo_full && !bus.flush;
  assign accept   = bus.pc_valid && pc_ready;
  assign push     = (state_q == WAIT) && bus.imem_ack && !bus.flush;
  assign pop      = head_valid && bus.if_ready;

  // Memory handshake FSM; request and address are registered outputs.
  always_ff @(posedge CLK or posedge MasterReset) begin
    if (MasterReset) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            imem_addr_q <= bus.pc_in;
            imem_req_q  <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end else if (bus.flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.imem_ack) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (MasterReset),
    .clear_i (bus.flush),
    .push_i  (push),
    .wdata_i ({imem_addr_q, bus.imem_rdata}),
    .pop_i   (pop),
    .rdata_o (head),
    .valid_o (head_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign bus.pc_ready  = pc_ready;
  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.if_valid  = head_valid;
  assign bus.if_pc     = head[ENTRY_W-1:DATA_W];
  assign bus.if_instr  = head[DATA_W-1:0];
  assign bus.count     = fifo_count;

endmodule
